// File: rtl/adder_pkg.sv
// Shared types and defaults for the adder_unit datapath.
package adder_pkg;
  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic {
    OP_ADD = 1'b0,
    OP_SUB = 1'b1
  } op_e;

  typedef struct packed {
    logic carry;
    logic overflow;
    logic zero;
  } flags_t;
endpackage

// File: rtl/add_sub_core.sv
// Combinational add/subtract with carry/borrow, signed overflow and unsigned clamp.
module add_sub_core
  import adder_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  op_e              op,
  input  logic             sat_en,
  output logic [WIDTH-1:0] result,
  output flags_t           flags
);
  logic [WIDTH:0]   w_sum;
  logic [WIDTH-1:0] w_b_eff;
  logic [WIDTH-1:0] w_raw;
  logic             w_cout;
  logic             w_carry;
  logic             w_ovf;
  logic             w_is_sub;

  assign w_is_sub = (op == OP_SUB);
  assign w_b_eff  = w_is_sub ? ~b : b;
  assign w_sum    = {1'b0, a} + {1'b0, w_b_eff} + {{WIDTH{1'b0}}, w_is_sub};
  assign w_raw    = w_sum[WIDTH-1:0];
  assign w_cout   = w_sum[WIDTH];

  // For subtraction the adder's carry-out means "no borrow", so invert it.
  assign w_carry = w_is_sub ? ~w_cout : w_cout;

  always_comb begin
    w_ovf = 1'b0;
    if (w_is_sub)
      w_ovf = (a[WIDTH-1] != b[WIDTH-1]) && (w_raw[WIDTH-1] != a[WIDTH-1]);
    else
      w_ovf = (a[WIDTH-1] == b[WIDTH-1]) && (w_raw[WIDTH-1] != a[WIDTH-1]);
  end

  always_comb begin
    result = w_raw;
    if (sat_en && w_carry)
      result = w_is_sub ? '0 : '1;
  end

  assign flags.carry    = w_carry;
  assign flags.overflow = w_ovf;
  assign flags.zero     = (result == '0);
endmodule

// File: rtl/adder_unit.sv
// Registered add/subtract unit: one pipeline stage around add_sub_core, valid tag alongside.
module adder_unit
  import adder_pkg::*;
#(
  parameter int             WIDTH       = DEFAULT_WIDTH,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  input  logic             sat_en,
  output logic [WIDTH-1:0] c,
  output logic             out_valid,
  output logic             carry,
  output logic             overflow,
  output logic             zero
);
  logic [WIDTH-1:0] w_result;
  flags_t           w_flags;
  op_e              w_op;

  logic [WIDTH-1:0] r_c;
  flags_t           r_flags;
  logic             r_valid;

  assign w_op = sub ? OP_SUB : OP_ADD;

  add_sub_core #(.WIDTH(WIDTH)) u_core (
    .a      (a),
    .b      (b),
    .op     (w_op),
    .sat_en (sat_en),
    .result (w_result),
    .flags  (w_flags)
  );

  // Result and flags hold when no operation is accepted; only the valid tag drops.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_c     <= RESET_VALUE;
      r_flags <= '0;
      r_valid <= 1'b0;
    end else begin
      r_valid <= in_valid;
      if (in_valid) begin
        r_c     <= w_result;
        r_flags <= w_flags;
      end
    end
  end

  assign c         = r_c;
  assign out_valid = r_valid;
  assign carry     = r_flags.carry;
  assign overflow  = r_flags.overflow;
  assign zero      = r_flags.zero;
endmodule

// File: tb/tb_adder_unit.sv
// Directed-vector bench for adder_unit at the default 8-bit width.
module tb_adder_unit;
  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic [7:0] a, b;
  logic       sub, sat_en;
  logic [7:0] c;
  logic       out_valid, carry, overflow, zero;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  adder_unit dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .a         (a),
    .b         (b),
    .sub       (sub),
    .sat_en    (sat_en),
    .c         (c),
    .out_valid (out_valid),
    .carry     (carry),
    .overflow  (overflow),
    .zero      (zero)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // Drive one operation, clock it in, then check all outputs 1 time unit after the edge.
  task automatic op(input string tag, input logic [7:0] ia, input logic [7:0] ib,
                    input logic isub, input logic isat,
                    input logic [7:0] ec, input logic ecy, input logic eov, input logic ez);
    a = ia; b = ib; sub = isub; sat_en = isat; in_valid = 1'b1;
    @(posedge clk); #1;
    chk({tag, ".c"},        c,         ec);
    chk({tag, ".carry"},    carry,     ecy);
    chk({tag, ".overflow"}, overflow,  eov);
    chk({tag, ".zero"},     zero,      ez);
    chk({tag, ".valid"},    out_valid, 1'b1);
  endtask

  initial begin
    rst = 1'b0; in_valid = 1'b1; a = 8'd6; b = 8'd3; sub = 1'b0; sat_en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("rst.c", c, 8'd0);
      chk("rst.valid", out_valid, 1'b0);
    end
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("first.c", c, 8'd9);
    chk("first.carry", carry, 1'b0);
    chk("first.overflow", overflow, 1'b0);
    chk("first.zero", zero, 1'b0);
    chk("first.valid", out_valid, 1'b1);

    //  tag          a     b    sub  sat   c     cy  ov  z
    op("wrap",      250,  10,  0,   0,    4,    1,  0,  0);
    op("sat_add",   250,  10,  0,   1,    255,  1,  0,  0);
    op("sub_neg",   3,    6,   1,   0,    253,  1,  0,  0);
    op("sat_sub",   3,    6,   1,   1,    0,    1,  0,  1);
    op("ovf_add",   127,  1,   0,   0,    128,  0,  1,  0);
    op("ovf_sub",   128,  1,   1,   0,    127,  0,  1,  0);
    op("max_p1",    255,  1,   0,   0,    0,    1,  0,  1);
    op("zero_m1",   0,    1,   1,   0,    255,  1,  0,  0);
    op("eq_sub",    5,    5,   1,   0,    0,    0,  0,  1);
    op("sat_nocy",  100,  20,  0,   1,    120,  0,  0,  0);

    op("s1",        1,    1,   0,   0,    2,    0,  0,  0);
    op("s2",        2,    2,   0,   0,    4,    0,  0,  0);
    op("s3",        0,    0,   0,   0,    0,    0,  0,  1);
    in_valid = 1'b0; a = 8'd77; b = 8'd9;
    @(posedge clk); #1;
    chk("hold.valid", out_valid, 1'b0);
    chk("hold.c", c, 8'd0);
    chk("hold.zero", zero, 1'b1);

    op("pre_rst",   5,    5,   0,   0,    10,   0,  0,  0);
    a = 8'd1; b = 8'd2; in_valid = 1'b1;
    #2 rst = 1'b0;
    #1;
    chk("async.c", c, 8'd0);
    chk("async.valid", out_valid, 1'b0);
    chk("async.zero", zero, 1'b0);
    in_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("post_rst.valid", out_valid, 1'b0);
    chk("post_rst.c", c, 8'd0);
    op("post_rst",  1,    2,   0,   0,    3,    0,  0,  0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
